ctrl_to_axilite: RTL and testbench
==================================

Name: ctrl_to_axilite

Overview:
- Host-side master bridge that converts the emulator's simple ctrl register-access bus into AXI4-Lite master transactions.
- It is the initiator counterpart of the AXI-Lite-to-ctrl responder. It lets platform logic, such as a scan/checkpoint sequencer, drive any AXI-Lite register slave.
- One transaction is in flight at a time. Every AXI-side output is registered.

Parameters:
- ADDR_WIDTH, 12, width of ctrl and AXI addresses.
- DATA_WIDTH, 32, data width. Only 32 is supported; any other value is a synthesis-time error.

Ports:
- clk  input  1  host clock
- rst  input  1  synchronous active-high reset
- ctrl_ready  output  1  bridge idle; a request is accepted only in a cycle where this is 1
- ctrl_wen  input  1  write request (single-cycle)
- ctrl_waddr  input  ADDR_WIDTH  write address
- ctrl_wdata  input  32  write data
- ctrl_wstrb  input  4  byte strobes
- ctrl_wdone  output  1  one-cycle pulse: write response received
- ctrl_wresp  output  2  BRESP of completed write; valid while ctrl_wdone=1
- ctrl_ren  input  1  read request (single-cycle)
- ctrl_raddr  input  ADDR_WIDTH  read address
- ctrl_rvalid  output  1  one-cycle pulse: read data returned
- ctrl_rdata  output  32  read data; held until the next read completes
- ctrl_rresp  output  2  RRESP of completed read; valid while ctrl_rvalid=1
- m_axilite_aw{valid,ready,addr,prot}  out,in,out[ADDR_WIDTH],out[3]
- m_axilite_w{valid,ready,data,strb}  out,in,out[32],out[4]
- m_axilite_b{valid,ready,resp}  in,out,in[2]
- m_axilite_ar{valid,ready,addr,prot}  out,in,out[ADDR_WIDTH],out[3]
- m_axilite_r{valid,ready,data,resp}  in,out,in[32],in[2]

Behaviour:
- Clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state IDLE, so ctrl_ready=1.
  - All AXI valid/ready outputs 0.
  - ctrl_wdone=0, ctrl_rvalid=0, ctrl_rdata=0, ctrl_wresp=0, ctrl_rresp=0.
  - awaddr/araddr/wdata/wstrb = 0.
- awprot and arprot are constant 3'b000.
- States: IDLE, W_REQ, W_RESP, R_ADDR, R_DATA.
- IDLE:
  - ctrl_wen=1 latches waddr, wdata and wstrb, asserts awvalid=wvalid=1 next cycle, and moves to W_REQ.
  - Otherwise ctrl_ren=1 latches raddr, asserts arvalid=1 next cycle, and moves to R_ADDR.
  - If wen and ren are both asserted in the same cycle, the write wins and the read is dropped. The requester must re-issue it.
- W_REQ:
  - AW and W complete independently.
  - awvalid drops the cycle after its awvalid&awready handshake; wvalid drops the cycle after its wvalid&wready handshake.
  - Internal aw_done/w_done flags record completion.
  - When both are complete (including the case where both complete in the same cycle), go to W_RESP with bready=1.
- W_RESP:
  - On bvalid&bready: bready goes to 0, ctrl_wdone=1 and ctrl_wresp=bresp for one cycle, state returns to IDLE.
- R_ADDR:
  - On arvalid&arready: arvalid goes to 0, rready=1, go to R_DATA.
- R_DATA:
  - On rvalid&rready: capture rdata/rresp into ctrl_rdata/ctrl_rresp, pulse ctrl_rvalid for one cycle, rready goes to 0, return to IDLE.
- ctrl_ready is 1 only in IDLE, and goes high in the same cycle as the completion pulse.
- Requests presented while ctrl_ready=0 are ignored, with no queueing.
- AXI compliance:
  - A valid never depends on the same-channel ready.
  - Once asserted, a valid stays high with stable payload until its handshake.
  - ready outputs are asserted only in the states that wait for them.
- Minimum latency, with slave readys and responses immediate:
  - Write: request at cycle 0; AW/W handshake at cycle 1; B handshake at cycle 2; ctrl_wdone at cycle 3.
  - Read: request at cycle 0; AR handshake at cycle 1; R handshake at cycle 2; ctrl_rvalid at cycle 3.
- Non-OKAY bresp/rresp values are passed through unchanged and do not stall the bridge.
- Reset mid-transaction forces IDLE in the next cycle and deasserts all valids/readys. The in-flight transaction is abandoned; the slave is required to share the reset.

Test Plan:
- Write, slave always ready: wen with addr 0x010, data 0xDEADBEEF, strb 0xF -> aw/w valid at cycle 1 with that payload; bready at cycle 2; bresp=0 -> ctrl_wdone at cycle 3 with wresp=0; ctrl_ready=1 at cycle 3.
- Skewed write: awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle; awvalid held with addr stable until its handshake; exactly one B wait; exactly one wdone pulse.
- Read: ren with addr 0x024; arready delayed 2 cycles; rvalid returns 0x12345678 with rresp=2 -> ctrl_rvalid pulse with rdata=0x12345678 and rresp=2; ctrl_rdata holds that value afterwards.
- Simultaneous wen+ren in IDLE -> only the write is issued; arvalid never asserts; a ren asserted during W_RESP is ignored.
- Back-to-back: a read issued in the completion cycle of a write (ctrl_ready=1) -> accepted; arvalid=1 on the next cycle.
- rst asserted in R_DATA while rvalid=0 -> next cycle rready=0, ctrl_ready=1, no ctrl_rvalid pulse.

Source files
------------

// File: rtl/ctrl_to_axilite.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ctrl_to_axilite
//  Purpose  : Host-side master bridge. Converts single-cycle ctrl bus register
//             requests into AXI4-Lite master transactions, one at a time.
//  Ports    : clk/rst          - host clock, synchronous active-high reset
//             ctrl_*           - ctrl request side (ready, write, read, done)
//             m_axilite_aw*    - AXI write address channel (master)
//             m_axilite_w*     - AXI write data channel (master)
//             m_axilite_b*     - AXI write response channel (master)
//             m_axilite_ar*    - AXI read address channel (master)
//             m_axilite_r*     - AXI read data channel (master)
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_to_axilite #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    ctrl_ready,
   input  logic                    ctrl_wen,
   input  logic [ADDR_WIDTH-1:0]   ctrl_waddr,
   input  logic [DATA_WIDTH-1:0]   ctrl_wdata,
   input  logic [DATA_WIDTH/8-1:0] ctrl_wstrb,
   output logic                    ctrl_wdone,
   output logic [1:0]              ctrl_wresp,
   input  logic                    ctrl_ren,
   input  logic [ADDR_WIDTH-1:0]   ctrl_raddr,
   output logic                    ctrl_rvalid,
   output logic [DATA_WIDTH-1:0]   ctrl_rdata,
   output logic [1:0]              ctrl_rresp,
   output logic                    m_axilite_awvalid,
   input  logic                    m_axilite_awready,
   output logic [ADDR_WIDTH-1:0]   m_axilite_awaddr,
   output logic [2:0]              m_axilite_awprot,
   output logic                    m_axilite_wvalid,
   input  logic                    m_axilite_wready,
   output logic [DATA_WIDTH-1:0]   m_axilite_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axilite_wstrb,
   input  logic                    m_axilite_bvalid,
   output logic                    m_axilite_bready,
   input  logic [1:0]              m_axilite_bresp,
   output logic                    m_axilite_arvalid,
   input  logic                    m_axilite_arready,
   output logic [ADDR_WIDTH-1:0]   m_axilite_araddr,
   output logic [2:0]              m_axilite_arprot,
   input  logic                    m_axilite_rvalid,
   output logic                    m_axilite_rready,
   input  logic [DATA_WIDTH-1:0]   m_axilite_rdata,
   input  logic [1:0]              m_axilite_rresp
);

   generate
      if (DATA_WIDTH != 32) begin : g_bad_data_width
         $error("ctrl_to_axilite: DATA_WIDTH must be 32");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_W_REQ  = 3'd1,
      ST_W_RESP = 3'd2,
      ST_R_ADDR = 3'd3,
      ST_R_DATA = 3'd4
   } state_t;

   state_t                    r_state,   w_state;
   logic                      r_awvalid, w_awvalid;
   logic [ADDR_WIDTH-1:0]     r_awaddr,  w_awaddr;
   logic                      r_wvalid,  w_wvalid;
   logic [DATA_WIDTH-1:0]     r_wdata,   w_wdata;
   logic [DATA_WIDTH/8-1:0]   r_wstrb,   w_wstrb;
   logic                      r_aw_done, w_aw_done;
   logic                      r_w_done,  w_w_done;
   logic                      r_bready,  w_bready;
   logic                      r_arvalid, w_arvalid;
   logic [ADDR_WIDTH-1:0]     r_araddr,  w_araddr;
   logic                      r_rready,  w_rready;
   logic                      r_wdone,   w_wdone;
   logic [1:0]                r_wresp,   w_wresp;
   logic                      r_rvalid,  w_rvalid;
   logic [DATA_WIDTH-1:0]     r_rdata,   w_rdata;
   logic [1:0]                r_rresp,   w_rresp;

   logic w_aw_fire;
   logic w_w_fire;

   assign w_aw_fire = r_awvalid & m_axilite_awready;
   assign w_w_fire  = r_wvalid  & m_axilite_wready;

   always_comb begin
      w_state   = r_state;
      w_awvalid = r_awvalid;
      w_awaddr  = r_awaddr;
      w_wvalid  = r_wvalid;
      w_wdata   = r_wdata;
      w_wstrb   = r_wstrb;
      w_aw_done = r_aw_done;
      w_w_done  = r_w_done;
      w_bready  = r_bready;
      w_arvalid = r_arvalid;
      w_araddr  = r_araddr;
      w_rready  = r_rready;
      w_wdone   = 1'b0;
      w_wresp   = r_wresp;
      w_rvalid  = 1'b0;
      w_rdata   = r_rdata;
      w_rresp   = r_rresp;

      case (r_state)
         ST_IDLE: begin
            // Write has priority; a simultaneous read is dropped.
            if (ctrl_wen) begin
               w_awaddr  = ctrl_waddr;
               w_wdata   = ctrl_wdata;
               w_wstrb   = ctrl_wstrb;
               w_awvalid = 1'b1;
               w_wvalid  = 1'b1;
               w_aw_done = 1'b0;
               w_w_done  = 1'b0;
               w_state   = ST_W_REQ;
            end else if (ctrl_ren) begin
               w_araddr  = ctrl_raddr;
               w_arvalid = 1'b1;
               w_state   = ST_R_ADDR;
            end
         end
         ST_W_REQ: begin
            // AW and W handshake independently; leave once both have landed,
            // counting a handshake happening in this very cycle.
            if (w_aw_fire) begin
               w_awvalid = 1'b0;
               w_aw_done = 1'b1;
            end
            if (w_w_fire) begin
               w_wvalid = 1'b0;
               w_w_done = 1'b1;
            end
            if ((r_aw_done | w_aw_fire) && (r_w_done | w_w_fire)) begin
               w_bready = 1'b1;
               w_state  = ST_W_RESP;
            end
         end
         ST_W_RESP: begin
            if (m_axilite_bvalid && r_bready) begin
               w_bready = 1'b0;
               w_wdone  = 1'b1;
               w_wresp  = m_axilite_bresp;
               w_state  = ST_IDLE;
            end
         end
         ST_R_ADDR: begin
            if (r_arvalid && m_axilite_arready) begin
               w_arvalid = 1'b0;
               w_rready  = 1'b1;
               w_state   = ST_R_DATA;
            end
         end
         ST_R_DATA: begin
            if (m_axilite_rvalid && r_rready) begin
               w_rready = 1'b0;
               w_rvalid = 1'b1;
               w_rdata  = m_axilite_rdata;
               w_rresp  = m_axilite_rresp;
               w_state  = ST_IDLE;
            end
         end
         default: begin
            w_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_awvalid <= 1'b0;
         r_awaddr  <= '0;
         r_wvalid  <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_bready  <= 1'b0;
         r_arvalid <= 1'b0;
         r_araddr  <= '0;
         r_rready  <= 1'b0;
         r_wdone   <= 1'b0;
         r_wresp   <= 2'b00;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= 2'b00;
      end else begin
         r_state   <= w_state;
         r_awvalid <= w_awvalid;
         r_awaddr  <= w_awaddr;
         r_wvalid  <= w_wvalid;
         r_wdata   <= w_wdata;
         r_wstrb   <= w_wstrb;
         r_aw_done <= w_aw_done;
         r_w_done  <= w_w_done;
         r_bready  <= w_bready;
         r_arvalid <= w_arvalid;
         r_araddr  <= w_araddr;
         r_rready  <= w_rready;
         r_wdone   <= w_wdone;
         r_wresp   <= w_wresp;
         r_rvalid  <= w_rvalid;
         r_rdata   <= w_rdata;
         r_rresp   <= w_rresp;
      end
   end

   assign ctrl_ready        = (r_state == ST_IDLE);
   assign ctrl_wdone        = r_wdone;
   assign ctrl_wresp        = r_wresp;
   assign ctrl_rvalid       = r_rvalid;
   assign ctrl_rdata        = r_rdata;
   assign ctrl_rresp        = r_rresp;
   assign m_axilite_awvalid = r_awvalid;
   assign m_axilite_awaddr  = r_awaddr;
   assign m_axilite_awprot  = 3'b000;
   assign m_axilite_wvalid  = r_wvalid;
   assign m_axilite_wdata   = r_wdata;
   assign m_axilite_wstrb   = r_wstrb;
   assign m_axilite_bready  = r_bready;
   assign m_axilite_arvalid = r_arvalid;
   assign m_axilite_araddr  = r_araddr;
   assign m_axilite_arprot  = 3'b000;
   assign m_axilite_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_to_axilite.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_to_axilite
//  Purpose  : Self-checking bench for ctrl_to_axilite. A behavioural AXI-Lite
//             slave with adjustable per-channel delays sits on the master
//             side; a word-array reference model predicts read data,
//             responses and completion latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_to_axilite;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        ctrl_ready, ctrl_wen = 0, ctrl_wdone, ctrl_ren = 0, ctrl_rvalid;
   logic [11:0] ctrl_waddr = 0, ctrl_raddr = 0;
   logic [31:0] ctrl_wdata = 0, ctrl_rdata;
   logic [3:0]  ctrl_wstrb = 0;
   logic [1:0]  ctrl_wresp, ctrl_rresp;
   logic        awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
   logic        arvalid, arready = 0, rvalid = 0, rready;
   logic [11:0] awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic [31:0] wdata, rdata = 0;
   logic [3:0]  wstrb;
   logic [1:0]  bresp = 0, rresp = 0;

   ctrl_to_axilite #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .ctrl_ready(ctrl_ready),
      .ctrl_wen(ctrl_wen), .ctrl_waddr(ctrl_waddr), .ctrl_wdata(ctrl_wdata),
      .ctrl_wstrb(ctrl_wstrb), .ctrl_wdone(ctrl_wdone), .ctrl_wresp(ctrl_wresp),
      .ctrl_ren(ctrl_ren), .ctrl_raddr(ctrl_raddr), .ctrl_rvalid(ctrl_rvalid),
      .ctrl_rdata(ctrl_rdata), .ctrl_rresp(ctrl_rresp),
      .m_axilite_awvalid(awvalid), .m_axilite_awready(awready),
      .m_axilite_awaddr(awaddr), .m_axilite_awprot(awprot),
      .m_axilite_wvalid(wvalid), .m_axilite_wready(wready),
      .m_axilite_wdata(wdata), .m_axilite_wstrb(wstrb),
      .m_axilite_bvalid(bvalid), .m_axilite_bready(bready), .m_axilite_bresp(bresp),
      .m_axilite_arvalid(arvalid), .m_axilite_arready(arready),
      .m_axilite_araddr(araddr), .m_axilite_arprot(arprot),
      .m_axilite_rvalid(rvalid), .m_axilite_rready(rready),
      .m_axilite_rdata(rdata), .m_axilite_rresp(rresp)
   );

   int total = 0;
   int bad   = 0;

   // slave knobs
   int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
   logic [1:0]  b_resp_v = 0, r_resp_v = 0;

   logic [31:0] slv_mem [0:4095];
   logic [31:0] ref_mem [0:4095];

   // slave state
   bit          have_aw = 0, have_w = 0, b_pend = 0, r_pend = 0;
   logic [11:0] cap_awaddr = 0, cap_araddr = 0;
   logic [31:0] cap_wdata = 0;
   logic [3:0]  cap_wstrb = 0;
   int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
   int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
   int          n_wdone = 0, n_rvalid = 0, proto_err = 0;

   // previous-cycle values for valid/payload stability checking
   bit          prev_ok = 0;
   logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
   logic [11:0] p_awaddr = 0, p_araddr = 0;
   logic [31:0] p_wdata = 0;
   logic [3:0]  p_wstrb = 0;

   // Handshake observation and slave memory update at the active edge.
   always @(posedge clk) begin
      if (rst) begin
         have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0; prev_ok = 0;
      end else begin
         if (prev_ok) begin
            if (p_awv && !p_awr && (!awvalid || awaddr !== p_awaddr)) proto_err++;
            if (p_wv && !p_wr && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) proto_err++;
            if (p_arv && !p_arr && (!arvalid || araddr !== p_araddr)) proto_err++;
         end
         if (awprot !== 3'b000 || arprot !== 3'b000) proto_err++;
         if (awvalid && awready) begin have_aw = 1; cap_awaddr = awaddr; n_aw++; end
         if (wvalid && wready) begin have_w = 1; cap_wdata = wdata; cap_wstrb = wstrb; n_w++; end
         if (bvalid && bready) begin b_pend = 0; n_b++; end
         if (have_aw && have_w) begin
            for (int i = 0; i < 4; i++)
               if (cap_wstrb[i]) slv_mem[cap_awaddr][8*i +: 8] = cap_wdata[8*i +: 8];
            have_aw = 0; have_w = 0; b_pend = 1;
         end
         if (arvalid && arready) begin r_pend = 1; cap_araddr = araddr; n_ar++; end
         if (rvalid && rready) begin r_pend = 0; n_r++; end
         if (ctrl_wdone)  n_wdone++;
         if (ctrl_rvalid) n_rvalid++;
         prev_ok = 1;
      end
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
      p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
      p_arv = arvalid; p_arr = arready; p_araddr = araddr;
   end

   // Slave drive on the falling edge; readys and response valids appear
   // after the programmed number of waiting cycles.
   always @(negedge clk) begin
      if (rst) begin
         awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
         aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      end else begin
         awready = awvalid && (aw_wait >= aw_dly); aw_wait = awvalid ? aw_wait + 1 : 0;
         wready  = wvalid  && (w_wait  >= w_dly);  w_wait  = wvalid  ? w_wait  + 1 : 0;
         arready = arvalid && (ar_wait >= ar_dly); ar_wait = arvalid ? ar_wait + 1 : 0;
         bvalid  = b_pend  && (b_wait  >= b_dly);  b_wait  = b_pend  ? b_wait  + 1 : 0;
         rvalid  = r_pend  && (r_wait  >= r_dly);  r_wait  = r_pend  ? r_wait  + 1 : 0;
         bresp   = b_resp_v;
         rresp   = r_resp_v;
         rdata   = slv_mem[cap_araddr];
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
      logic [31:0] m;
      m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      return (old & ~m) | (nw & m);
   endfunction

   task automatic set_dly(input int a, input int w, input int ar, input int b, input int r);
      aw_dly = a; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
   endtask

   task automatic test_reset;
      rst = 1; ctrl_wen = 1; ctrl_waddr = 12'h3FC; ctrl_wdata = 32'hFFFF_FFFF; ctrl_wstrb = 4'hF;
      repeat (3) tick;
      ctrl_wen = 0;
      total++; if (ctrl_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", ctrl_ready); end
      total++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin bad++;
         $display("FAIL rst_axi_vr got=%b want=00000", {awvalid, wvalid, bready, arvalid, rready}); end
      total++; if ({ctrl_wdone, ctrl_rvalid, ctrl_wresp, ctrl_rresp} !== 6'b0) begin bad++;
         $display("FAIL rst_ctrl_out got=%b want=000000", {ctrl_wdone, ctrl_rvalid, ctrl_wresp, ctrl_rresp}); end
      total++; if ({ctrl_rdata, awaddr, araddr, wdata, wstrb} !== 92'h0) begin bad++;
         $display("FAIL rst_payload got=%h want=0", {ctrl_rdata, awaddr, araddr, wdata, wstrb}); end
      rst = 0;
      tick;
   endtask

   task automatic test_write_basic;
      set_dly(0, 0, 0, 0, 0); b_resp_v = 2'd0;
      ctrl_wen = 1; ctrl_waddr = 12'h010; ctrl_wdata = 32'hDEADBEEF; ctrl_wstrb = 4'hF;
      ref_mem[12'h010] = merge(ref_mem[12'h010], 32'hDEADBEEF, 4'hF);
      tick; ctrl_wen = 0; ctrl_wdata = 0; ctrl_waddr = 0; ctrl_wstrb = 0;
      total++; if ({awvalid, wvalid, bready, ctrl_ready} !== 4'b1100) begin bad++;
         $display("FAIL wr_c1_ctl got=%b want=1100", {awvalid, wvalid, bready, ctrl_ready}); end
      total++; if ({awaddr, wdata, wstrb} !== {12'h010, 32'hDEADBEEF, 4'hF}) begin bad++;
         $display("FAIL wr_c1_payload got=%h want=%h", {awaddr, wdata, wstrb}, {12'h010, 32'hDEADBEEF, 4'hF}); end
      tick;
      total++; if ({awvalid, wvalid, bready} !== 3'b001) begin bad++;
         $display("FAIL wr_c2_ctl got=%b want=001", {awvalid, wvalid, bready}); end
      tick;
      total++; if ({ctrl_wdone, ctrl_wresp, ctrl_ready, bready} !== 5'b10010) begin bad++;
         $display("FAIL wr_c3_done got=%b want=10010", {ctrl_wdone, ctrl_wresp, ctrl_ready, bready}); end
      tick;
      total++; if (ctrl_wdone !== 1'b0) begin bad++; $display("FAIL wr_c4_pulse got=%b want=0", ctrl_wdone); end
   endtask

   task automatic test_skewed_write;
      int aw_c = 0, w_c = 0, b_c = 0, done_c = 0;
      set_dly(3, 0, 0, 0, 0); b_resp_v = 2'd1;
      n_aw = 0; n_w = 0;
      ctrl_wen = 1; ctrl_waddr = 12'h0A4; ctrl_wdata = 32'h0BAD_F00D; ctrl_wstrb = 4'hF;
      ref_mem[12'h0A4] = 32'h0BAD_F00D;
      for (int c = 1; c <= 15; c++) begin
         tick; ctrl_wen = 0; ctrl_waddr = 12'hFFF;
         if (awvalid) begin
            aw_c++;
            total++; if (awaddr !== 12'h0A4) begin bad++; $display("FAIL skew_awaddr got=%h want=0a4", awaddr); end
         end
         if (wvalid) w_c++;
         if (bready) b_c++;
         if (ctrl_wdone) begin
            done_c++;
            total++; if (ctrl_wresp !== 2'd1) begin bad++; $display("FAIL skew_wresp got=%0d want=1", ctrl_wresp); end
         end
      end
      total++; if (w_c !== 1) begin bad++; $display("FAIL skew_wvalid_cycles got=%0d want=1", w_c); end
      total++; if (aw_c !== 4) begin bad++; $display("FAIL skew_awvalid_cycles got=%0d want=4", aw_c); end
      total++; if (b_c !== 1) begin bad++; $display("FAIL skew_bready_cycles got=%0d want=1", b_c); end
      total++; if (done_c !== 1) begin bad++; $display("FAIL skew_wdone_pulses got=%0d want=1", done_c); end
      total++; if ({n_aw, n_w} !== {32'd1, 32'd1}) begin bad++; $display("FAIL skew_hs got=%0d/%0d want=1/1", n_aw, n_w); end
   endtask

   task automatic test_read;
      int ar_c = 0, pulses = 0, pulse_cyc = -1;
      set_dly(0, 0, 2, 0, 0); r_resp_v = 2'd2;
      slv_mem[12'h024] = 32'h12345678; ref_mem[12'h024] = 32'h12345678;
      ctrl_ren = 1; ctrl_raddr = 12'h024;
      for (int c = 1; c <= 20; c++) begin
         tick; ctrl_ren = 0; ctrl_raddr = 12'h000;
         if (arvalid) begin
            ar_c++;
            total++; if (araddr !== 12'h024) begin bad++; $display("FAIL rd_araddr got=%h want=024", araddr); end
         end
         if (ctrl_rvalid) begin
            pulses++; pulse_cyc = c;
            total++; if ({ctrl_rdata, ctrl_rresp} !== {32'h12345678, 2'd2}) begin bad++;
               $display("FAIL rd_data got=%h/%0d want=12345678/2", ctrl_rdata, ctrl_rresp); end
         end
      end
      total++; if (ar_c !== 3) begin bad++; $display("FAIL rd_arvalid_cycles got=%0d want=3", ar_c); end
      total++; if (pulses !== 1) begin bad++; $display("FAIL rd_pulses got=%0d want=1", pulses); end
      total++; if (pulse_cyc !== 5) begin bad++; $display("FAIL rd_latency got=%0d want=5", pulse_cyc); end
      total++; if (ctrl_rdata !== 32'h12345678) begin bad++; $display("FAIL rd_hold got=%h want=12345678", ctrl_rdata); end
   endtask

   task automatic test_simultaneous;
      int ar_c = 0, b_c = 0;
      bit ren_sent = 0;
      set_dly(0, 0, 0, 2, 0); b_resp_v = 2'd0;
      n_aw = 0; n_ar = 0; n_wdone = 0; n_rvalid = 0;
      ctrl_wen = 1; ctrl_waddr = 12'h100; ctrl_wdata = 32'hCAFE_0001; ctrl_wstrb = 4'hF;
      ctrl_ren = 1; ctrl_raddr = 12'h200;
      ref_mem[12'h100] = 32'hCAFE_0001;
      for (int c = 1; c <= 20; c++) begin
         tick; ctrl_wen = 0;
         if (bready && !ren_sent) begin ctrl_ren = 1; ren_sent = 1; end
         else ctrl_ren = 0;
         if (arvalid) ar_c++;
         if (bready) b_c++;
      end
      total++; if (ar_c !== 0) begin bad++; $display("FAIL sim_arvalid_cycles got=%0d want=0", ar_c); end
      total++; if ({n_aw, n_ar} !== {32'd1, 32'd0}) begin bad++; $display("FAIL sim_hs got=aw%0d/ar%0d want=aw1/ar0", n_aw, n_ar); end
      total++; if ({n_wdone, n_rvalid} !== {32'd1, 32'd0}) begin bad++;
         $display("FAIL sim_pulses got=w%0d/r%0d want=w1/r0", n_wdone, n_rvalid); end
      total++; if (b_c !== 3) begin bad++; $display("FAIL sim_bready_cycles got=%0d want=3", b_c); end
   endtask

   task automatic test_back_to_back;
      bit found = 0;
      logic [31:0] exp_v;
      set_dly(0, 0, 0, 0, 0); b_resp_v = 0; r_resp_v = 0;
      slv_mem[12'h030] = 32'hAABBCCDD; ref_mem[12'h030] = 32'hAABBCCDD;
      ctrl_wen = 1; ctrl_waddr = 12'h030; ctrl_wdata = 32'h1122_3344; ctrl_wstrb = 4'b0101;
      ref_mem[12'h030] = merge(ref_mem[12'h030], 32'h1122_3344, 4'b0101);
      exp_v = ref_mem[12'h030];
      for (int c = 1; c <= 20 && !found; c++) begin
         tick; ctrl_wen = 0;
         if (ctrl_wdone) begin
            found = 1;
            total++; if (ctrl_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", ctrl_ready); end
            ctrl_ren = 1; ctrl_raddr = 12'h030;
         end
      end
      total++; if (!found) begin bad++; $display("FAIL b2b_wdone_timeout got=none want=pulse"); end
      tick; ctrl_ren = 0;
      total++; if ({arvalid, araddr} !== {1'b1, 12'h030}) begin bad++;
         $display("FAIL b2b_arvalid got=%b/%h want=1/030", arvalid, araddr); end
      found = 0;
      for (int c = 1; c <= 20 && !found; c++) begin
         tick;
         if (ctrl_rvalid) found = 1;
      end
      total++; if (!found || ctrl_rdata !== exp_v) begin bad++;
         $display("FAIL b2b_rdata got=%h (seen=%0d) want=%h", ctrl_rdata, found, exp_v); end
   endtask

   task automatic test_reset_mid_read;
      bit found = 0;
      set_dly(0, 0, 0, 0, 6);
      ctrl_ren = 1; ctrl_raddr = 12'h024;
      for (int c = 1; c <= 10 && !found; c++) begin
         tick; ctrl_ren = 0;
         if (rready) found = 1;
      end
      total++; if (!found) begin bad++; $display("FAIL rstrd_rready_timeout got=none want=rready"); end
      rst = 1;
      tick;
      rst = 0;
      n_rvalid = 0;
      total++; if ({rready, arvalid, ctrl_ready, ctrl_rvalid} !== 4'b0010) begin bad++;
         $display("FAIL rstrd_state got=%b want=0010", {rready, arvalid, ctrl_ready, ctrl_rvalid}); end
      total++; if (ctrl_rdata !== 32'h0) begin bad++; $display("FAIL rstrd_rdata got=%h want=0", ctrl_rdata); end
      repeat (10) tick;
      total++; if (n_rvalid !== 0) begin bad++; $display("FAIL rstrd_pulses got=%0d want=0", n_rvalid); end
   endtask

   task automatic test_random;
      int n_wr = 0, n_rd = 0, lat, exp_lat;
      bit found, is_wr;
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [1:0]  rsp;
      n_aw = 0; n_ar = 0;
      for (int t = 0; t < 40; t++) begin
         set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
         is_wr = ($urandom_range(0, 1) == 1);
         a = 12'h100 | {7'd0, 3'($urandom_range(0, 7)), 2'b00};
         d = $urandom; s = 4'($urandom_range(0, 15)); rsp = 2'($urandom_range(0, 3));
         total++; if (ctrl_ready !== 1'b1) begin bad++; $display("FAIL rnd_ready t=%0d got=%b want=1", t, ctrl_ready); end
         if (is_wr) begin
            b_resp_v = rsp; n_wr++;
            ctrl_wen = 1; ctrl_waddr = a; ctrl_wdata = d; ctrl_wstrb = s;
            ref_mem[a] = merge(ref_mem[a], d, s);
            exp_lat = ((aw_dly > w_dly) ? aw_dly : w_dly) + 3 + b_dly;
         end else begin
            r_resp_v = rsp; n_rd++;
            ctrl_ren = 1; ctrl_raddr = a;
            exp_lat = ar_dly + 3 + r_dly;
         end
         found = 0; lat = -1;
         for (int c = 1; c <= 60 && !found; c++) begin
            tick;
            if (!ctrl_ready) begin
               // junk requests while busy must be ignored
               ctrl_wen = 1'($urandom_range(0, 1)); ctrl_ren = 1'($urandom_range(0, 1));
               ctrl_waddr = 12'($urandom); ctrl_raddr = 12'($urandom); ctrl_wdata = $urandom;
            end else begin
               ctrl_wen = 0; ctrl_ren = 0;
            end
            if ((is_wr && ctrl_wdone) || (!is_wr && ctrl_rvalid)) begin found = 1; lat = c; end
         end
         ctrl_wen = 0; ctrl_ren = 0;
         total++; if (lat !== exp_lat) begin bad++;
            $display("FAIL rnd_latency t=%0d wr=%0d got=%0d want=%0d", t, is_wr, lat, exp_lat); end
         if (is_wr) begin
            total++; if (ctrl_wresp !== rsp) begin bad++; $display("FAIL rnd_wresp t=%0d got=%0d want=%0d", t, ctrl_wresp, rsp); end
         end else begin
            total++; if ({ctrl_rdata, ctrl_rresp} !== {ref_mem[a], rsp}) begin bad++;
               $display("FAIL rnd_rdata t=%0d addr=%h got=%h/%0d want=%h/%0d", t, a, ctrl_rdata, ctrl_rresp, ref_mem[a], rsp); end
         end
      end
      total++; if ({n_aw, n_ar} !== {n_wr, n_rd}) begin bad++;
         $display("FAIL rnd_hs_count got=aw%0d/ar%0d want=aw%0d/ar%0d", n_aw, n_ar, n_wr, n_rd); end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin slv_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
      test_reset;
      test_write_basic;
      test_skewed_write;
      test_read;
      test_simultaneous;
      test_back_to_back;
      test_reset_mid_read;
      test_random;
      total++; if (proto_err !== 0) begin bad++; $display("FAIL axi_valid_stability got=%0d want=0", proto_err); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
